qspi_psram_responder: RTL and testbench
=======================================

Name: qspi_psram_responder

Overview:
- Synthesizable QSPI PSRAM device emulator; the target end of the PSRAM controller's bus.
- Decodes the controller's command stream and serves data from an internal byte array: SPI-mode reset, read-ID and enter-quad commands, then quad 0xEB read and 0x38 write.
- Used in loopback simulation and in on-FPGA self-test builds in place of the physical chip; shares mem_clk with the controller and oversamples psram_sclk.

Parameters:
- ADDR_W, 12, byte address width of the backing array; depth 2**ADDR_W. The upper bits of the 24-bit bus address are ignored.
- ID_VALUE, 64'h0D5D_5A5A_1234_5678, 64-bit value returned MSB-first by 0x9F.
- DUMMY_CLKS, 6, wait clocks between the quad read address and the first data nibble.

Ports:
- mem_clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- psram_ce  in  1  chip enable, active-low.
- psram_sclk  in  1  serial clock from the controller; sampled in the mem_clk domain.
- sio_in  in  4  bus value seen at the pins.
- sio_out  out  4  value the responder drives.
- sio_oe  out  1  1 = responder drives the bus.
- qpi_mode  out  1  1 = quad mode active.
- bad_cmd  out  1  one-cycle pulse when an opcode is not recognised.

Behaviour:
Reset: sio_out=0, sio_oe=0, qpi_mode=0, bad_cmd=0, state=IDLE, rst_en=0. Array contents are not reset.

Clock edge detection:
- sclk_q is psram_sclk registered on mem_clk.
- rise = psram_sclk & ~sclk_q; fall = ~psram_sclk & sclk_q. Both use the live input.
- Input data is sampled on the mem_clk edge where rise=1.
- sio_out is updated on the edge where fall=1, so it is stable for the whole following high phase. The controller samples while sclk is high.

Chip enable:
- psram_ce=1 at any time forces state=IDLE and sio_oe=0 in the next cycle.
- Any partially collected opcode, address or byte is discarded.
- No array write is issued for an incomplete byte.
- CE high takes priority over a simultaneous rise.

States:
- IDLE -> CMD on psram_ce=0.
- CMD:
  - SPI mode: 8 rises, opcode bit from sio_in[0], MSB first.
  - Quad mode: 2 rises, nibbles from sio_in[3:0], high nibble first.
- Opcode decode on the final CMD rise:
  - 0x66: rst_en=1, go to IGNORE.
  - 0x99: if rst_en then qpi_mode=0. Clear rst_en, go to IGNORE.
  - 0x35: qpi_mode=1, go to IGNORE.
  - 0xF5: qpi_mode=0, go to IGNORE.
  - 0x9F (SPI mode only): go to ADDR. After 24 rises go to IDOUT.
  - 0xEB / 0x38 (quad mode only): go to ADDR. Six nibble rises build addr[23:0].
  - Any other opcode, including 0x9F in quad mode or 0xEB/0x38 in SPI mode: pulse bad_cmd, go to IGNORE.
  - Any opcode other than 0x66 clears rst_en.
- IDOUT:
  - sio_oe=1; ID_VALUE shifted MSB-first on sio_out[1].
  - First bit is driven on the fall that ends the last address clock. 64 bits total.
  - Beyond 64 clocks, drive 0.
- DUMMY (0xEB):
  - sio_oe=1 from state entry, driving 0.
  - Count DUMMY_CLKS falls. On the last fall, drive the high nibble of mem[addr].
  - Then go to RDATA.
- RDATA:
  - Each fall alternates the low nibble, then the high nibble of the next byte.
  - The address increments after each low nibble and wraps modulo 2**ADDR_W.
  - Read data is prefetched one byte ahead, so the synchronous-read latency of 1 mem_clk is hidden. Back-to-back sclk edges are at least 2 mem_clk apart.
- WDATA (0x38):
  - sio_oe=0. Nibble pairs are collected, high nibble first.
  - mem[addr] is written on the second nibble's rise, then addr increments with wrap.
- IGNORE: sio_oe=0; wait for CE high.
- Unlimited burst length. Reset asserted mid-burst aborts immediately with no write.

Decomposition:
- Shared package psram_pkg:
  - opcode constants CMD_RSTEN=8'h66, CMD_RST=8'h99, CMD_RDID=8'h9F, CMD_QPI_EN=8'h35, CMD_QPI_EX=8'hF5, CMD_QREAD=8'hEB, CMD_QWRITE=8'h38.
  - state enum.
  - QREAD_DUMMY=6.
  - The controller will import the same constants.
- Sub-module psram_resp_ram: single-port 2**ADDR_W x 8, synchronous read with 1-cycle latency, write enable. It infers BRAM.

Test Plan:
- Boot sequence 0x66, 0x99, 0x9F+000000, 0x35 in SPI mode -> 64 bits on sio_out[1] equal ID_VALUE; qpi_mode=1 after 0x35; bad_cmd never pulses.
- Quad 0x38 @0x000040 with bytes 0x00..0x3F, then 0xEB @0x000040 -> after 6 dummy clocks, read data 0x00..0x3F in order, high nibble first.
- 0x38 @ (2**ADDR_W - 2) with 4 bytes AA BB CC DD -> array bytes [depth-2]=AA, [depth-1]=BB, [0]=CC, [1]=DD.
- CE raised after 3 nibbles of a 0x38 at 0x100 (mem[0x100]=0x11, mem[0x101]=0x22) -> mem[0x100] is the new byte, mem[0x101] stays 0x22, sio_oe=0 next cycle.
- 0xEB in SPI mode -> bad_cmd pulses once, sio_oe stays 0. 0x99 without a preceding 0x66 in quad mode -> qpi_mode stays 1.
- Reset asserted during a read burst -> next cycle sio_oe=0, qpi_mode=0, state IDLE.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared PSRAM command set and responder state encoding.
// Imported by the responder and by the controller so both ends agree on opcodes.
package psram_pkg;

  localparam logic [7:0] CMD_RSTEN  = 8'h66;
  localparam logic [7:0] CMD_RST    = 8'h99;
  localparam logic [7:0] CMD_RDID   = 8'h9F;
  localparam logic [7:0] CMD_QPI_EN = 8'h35;
  localparam logic [7:0] CMD_QPI_EX = 8'hF5;
  localparam logic [7:0] CMD_QREAD  = 8'hEB;
  localparam logic [7:0] CMD_QWRITE = 8'h38;

  localparam int unsigned QREAD_DUMMY = 6;
  localparam int unsigned BUS_ADDR_W  = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_IDOUT,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/qspi_psram_responder_if.sv
// QSPI PSRAM pin bundle between controller (master) and device/responder (slave).
//   psram_ce   : chip enable, active-low
//   psram_sclk : serial clock from the controller
//   sio_in     : value seen on the four data pins
//   sio_out    : value the responder drives, sio_oe = 1 when it drives
//   qpi_mode   : responder is in quad mode
//   bad_cmd    : one-cycle pulse on an unrecognised opcode
interface qspi_psram_responder_if;
  logic       psram_ce;
  logic       psram_sclk;
  logic [3:0] sio_in;
  logic [3:0] sio_out;
  logic       sio_oe;
  logic       qpi_mode;
  logic       bad_cmd;

  modport master (
    output psram_ce, psram_sclk, sio_in,
    input  sio_out, sio_oe, qpi_mode, bad_cmd
  );

  modport slave (
    input  psram_ce, psram_sclk, sio_in,
    output sio_out, sio_oe, qpi_mode, bad_cmd
  );
endinterface

// File: rtl/psram_resp_ram.sv
// Single-port backing array for the PSRAM responder, 2**ADDR_W x 8.
// Synchronous read (1-cycle latency, read-before-write), write enable.
//   mem_clk : clock
//   we_i    : write mem[addr_i] <= wdata_i
//   addr_i  : byte address
//   wdata_i : write byte
//   rdata_o : mem[addr_i] as of the previous cycle
module psram_resp_ram #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              mem_clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0] mem_q [DEPTH];

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge mem_clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/qspi_psram_responder.sv
// QSPI PSRAM device emulator: decodes the controller's command stream and
// serves reads/writes from an internal byte array. psram_sclk is oversampled
// on mem_clk; inputs are taken on sclk rise, outputs change on sclk fall.
//   mem_clk : clock shared with the controller
//   reset   : synchronous, active-high
//   bus     : slave side of the PSRAM pin bundle
module qspi_psram_responder
  import psram_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter logic [63:0] ID_VALUE   = 64'h0D5D_5A5A_1234_5678,
  parameter int unsigned DUMMY_CLKS = QREAD_DUMMY
) (
  input  logic                    mem_clk,
  input  logic                    reset,
  qspi_psram_responder_if.slave   bus
);

  localparam int unsigned CNT_W = 6;

  state_e                  state_q;
  logic                    sclk_q;
  logic [7:0]              op_q;
  logic [BUS_ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [63:0]             id_q;
  logic [7:0]              rd_byte_q;
  logic [3:0]              wr_nib_q;
  logic                    nib_lo_q;
  logic                    half_q;
  logic                    rst_en_q;
  logic                    qpi_q;
  logic [3:0]              sio_out_q;
  logic                    sio_oe_q;
  logic                    bad_cmd_q;

  logic                    rise_c;
  logic                    fall_c;
  logic [7:0]              op_d;
  logic [BUS_ADDR_W-1:0]   addr_d;
  logic                    cmd_last_c;
  logic                    addr_last_c;
  logic                    ram_we_c;
  logic [7:0]              ram_rdata;

  // Edge detect against the live sclk input.
  assign rise_c = bus.psram_sclk & ~sclk_q;
  assign fall_c = ~bus.psram_sclk & sclk_q;

  // Next opcode/address shift values and phase-end detection for both modes.
  always_comb begin
    op_d        = qpi_q ? {op_q[3:0], bus.sio_in} : {op_q[6:0], bus.sio_in[0]};
    addr_d      = qpi_q ? {addr_q[BUS_ADDR_W-5:0], bus.sio_in}
                        : {addr_q[BUS_ADDR_W-2:0], bus.sio_in[0]};
    cmd_last_c  = (cnt_q == (qpi_q ? CNT_W'(1) : CNT_W'(7)));
    addr_last_c = (cnt_q == (qpi_q ? CNT_W'(5) : CNT_W'(23)));
    // Write only on a completed byte; CE high and reset both suppress it.
    ram_we_c    = !reset && !bus.psram_ce && rise_c && (state_q == ST_WDATA) && half_q;
  end

  psram_resp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .mem_clk (mem_clk),
    .we_i    (ram_we_c),
    .addr_i  (addr_q[ADDR_W-1:0]),
    .wdata_i ({wr_nib_q, bus.sio_in}),
    .rdata_o (ram_rdata)
  );

  // Command FSM with registered pin outputs.
  always_ff @(posedge mem_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sclk_q    <= 1'b0;
      op_q      <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      rd_byte_q <= '0;
      wr_nib_q  <= '0;
      nib_lo_q  <= 1'b0;
      half_q    <= 1'b0;
      rst_en_q  <= 1'b0;
      qpi_q     <= 1'b0;
      sio_out_q <= '0;
      sio_oe_q  <= 1'b0;
      bad_cmd_q <= 1'b0;
    end else begin
      sclk_q    <= bus.psram_sclk;
      bad_cmd_q <= 1'b0;
      if (bus.psram_ce) begin
        // Deselect drops any partial opcode/address/byte.
        state_q   <= ST_IDLE;
        sio_oe_q  <= 1'b0;
        sio_out_q <= '0;
        cnt_q     <= '0;
        half_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_CMD;
            cnt_q   <= '0;
            op_q    <= '0;
          end

          ST_CMD: begin
            if (rise_c) begin
              op_q  <= op_d;
              cnt_q <= cnt_q + CNT_W'(1);
              if (cmd_last_c) begin
                cnt_q    <= '0;
                state_q  <= ST_IGNORE;
                rst_en_q <= 1'b0;
                case (op_d)
                  CMD_RSTEN:  rst_en_q <= 1'b1;
                  CMD_RST:    if (rst_en_q) qpi_q <= 1'b0;
                  CMD_QPI_EN: qpi_q <= 1'b1;
                  CMD_QPI_EX: qpi_q <= 1'b0;
                  CMD_RDID: begin
                    if (!qpi_q) state_q <= ST_ADDR;
                    else        bad_cmd_q <= 1'b1;
                  end
                  CMD_QREAD, CMD_QWRITE: begin
                    if (qpi_q) state_q <= ST_ADDR;
                    else       bad_cmd_q <= 1'b1;
                  end
                  default:    bad_cmd_q <= 1'b1;
                endcase
              end
            end
          end

          ST_ADDR: begin
            if (rise_c) begin
              addr_q <= addr_d;
              cnt_q  <= cnt_q + CNT_W'(1);
              if (addr_last_c) begin
                cnt_q <= '0;
                if (op_q == CMD_RDID) begin
                  state_q   <= ST_IDOUT;
                  sio_oe_q  <= 1'b1;
                  sio_out_q <= '0;
                  id_q      <= ID_VALUE;
                end else if (op_q == CMD_QREAD) begin
                  state_q   <= ST_DUMMY;
                  sio_oe_q  <= 1'b1;
                  sio_out_q <= '0;
                end else begin
                  state_q <= ST_WDATA;
                  half_q  <= 1'b0;
                end
              end
            end
          end

          // ID shifts out MSB-first on sio[1]; zeros fill in after 64 bits.
          ST_IDOUT: begin
            if (fall_c) begin
              sio_out_q <= {2'b00, id_q[63], 1'b0};
              id_q      <= {id_q[62:0], 1'b0};
            end
          end

          // The first fall here closes the last address clock and is not a
          // dummy clock, hence the compare against DUMMY_CLKS rather than -1.
          ST_DUMMY: begin
            if (fall_c) begin
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_W'(DUMMY_CLKS)) begin
                sio_out_q <= ram_rdata[7:4];
                rd_byte_q <= ram_rdata;
                addr_q    <= addr_q + BUS_ADDR_W'(1);
                nib_lo_q  <= 1'b1;
                state_q   <= ST_RDATA;
              end
            end
          end

          // addr_q runs one byte ahead so ram_rdata is ready at the next high nibble.
          ST_RDATA: begin
            if (fall_c) begin
              if (nib_lo_q) begin
                sio_out_q <= rd_byte_q[3:0];
                nib_lo_q  <= 1'b0;
              end else begin
                sio_out_q <= ram_rdata[7:4];
                rd_byte_q <= ram_rdata;
                addr_q    <= addr_q + BUS_ADDR_W'(1);
                nib_lo_q  <= 1'b1;
              end
            end
          end

          ST_WDATA: begin
            if (rise_c) begin
              if (half_q) begin
                half_q <= 1'b0;
                addr_q <= addr_q + BUS_ADDR_W'(1);
              end else begin
                wr_nib_q <= bus.sio_in;
                half_q   <= 1'b1;
              end
            end
          end

          ST_IGNORE: sio_oe_q <= 1'b0;

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.sio_out  = sio_out_q;
  assign bus.sio_oe   = sio_oe_q;
  assign bus.qpi_mode = qpi_q;
  assign bus.bad_cmd  = bad_cmd_q;

endmodule

// File: tb/tb_qspi_psram_responder.sv
// Directed bench for qspi_psram_responder: table of single commands checking
// mode and bad_cmd, plus hand sequences for ID read, quad write/read, wrap,
// CE abort and reset abort.
module tb_qspi_psram_responder;
  import psram_pkg::*;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [63:0] ID_VALUE = 64'h0D5D_5A5A_1234_5678;

  logic mem_clk = 1'b0;
  logic reset;

  qspi_psram_responder_if bus ();

  qspi_psram_responder #(
    .ADDR_W     (ADDR_W),
    .ID_VALUE   (ID_VALUE),
    .DUMMY_CLKS (6)
  ) dut (
    .mem_clk (mem_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 mem_clk = ~mem_clk;

  typedef struct {
    logic [7:0] op;
    logic       exp_qpi;
    int         exp_bad;
  } cmd_vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         bad_cnt  = 0;
  logic [7:0] wr_buf [64];
  logic [7:0] rd_buf [64];
  logic       rd_oe_all;
  logic       wr_oe_any;

  always @(negedge mem_clk) if (bus.bad_cmd === 1'b1) bad_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge mem_clk);
  endtask

  // One sclk period; returns sio_out/sio_oe seen late in the high phase.
  task automatic sclk_cycle(input logic [3:0] d, output logic [3:0] q, output logic oe);
    bus.sio_in = d;
    tick(1);
    bus.psram_sclk = 1'b1;
    tick(2);
    q  = bus.sio_out;
    oe = bus.sio_oe;
    bus.psram_sclk = 1'b0;
    tick(2);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    logic [3:0] q;
    logic       oe;
    for (int i = 0; i < 8; i++) sclk_cycle({3'b000, b[7-i]}, q, oe);
  endtask

  task automatic quad_byte(input logic [7:0] b);
    logic [3:0] q;
    logic       oe;
    sclk_cycle(b[7:4], q, oe);
    sclk_cycle(b[3:0], q, oe);
  endtask

  task automatic quad_addr(input logic [23:0] a);
    quad_byte(a[23:16]);
    quad_byte(a[15:8]);
    quad_byte(a[7:0]);
  endtask

  task automatic ce_low;
    bus.psram_ce = 1'b0;
    tick(2);
  endtask

  task automatic ce_high;
    bus.psram_ce = 1'b1;
    tick(2);
  endtask

  task automatic qwrite(input logic [23:0] a, input int n);
    logic [3:0] q;
    logic       oe;
    wr_oe_any = 1'b0;
    ce_low();
    quad_byte(CMD_QWRITE);
    quad_addr(a);
    for (int i = 0; i < n; i++) begin
      sclk_cycle(wr_buf[i][7:4], q, oe);
      wr_oe_any |= oe;
      sclk_cycle(wr_buf[i][3:0], q, oe);
      wr_oe_any |= oe;
    end
    ce_high();
  endtask

  // Address, six dummy clocks, then n bytes high nibble first.
  task automatic qread(input logic [23:0] a, input int n);
    logic [3:0] qh, ql;
    logic       oe1, oe2;
    ce_low();
    quad_byte(CMD_QREAD);
    quad_addr(a);
    for (int i = 0; i < 6; i++) sclk_cycle(4'h0, qh, oe1);
    rd_oe_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      sclk_cycle(4'h0, qh, oe1);
      sclk_cycle(4'h0, ql, oe2);
      rd_buf[i] = {qh, ql};
      if (!oe1 || !oe2) rd_oe_all = 1'b0;
    end
    ce_high();
  endtask

  cmd_vec_t vecs [13];

  initial begin
    logic [63:0] id_got;
    logic [3:0]  q, extra;
    logic        oe, oe_ok, cur_qpi;
    int          bad_before;

    vecs[0]  = '{8'h99, 1'b1, 0};
    vecs[1]  = '{8'h66, 1'b1, 0};
    vecs[2]  = '{8'h99, 1'b0, 0};
    vecs[3]  = '{8'hEB, 1'b0, 1};
    vecs[4]  = '{8'h38, 1'b0, 1};
    vecs[5]  = '{8'h12, 1'b0, 1};
    vecs[6]  = '{8'h35, 1'b1, 0};
    vecs[7]  = '{8'h9F, 1'b1, 1};
    vecs[8]  = '{8'hA5, 1'b1, 1};
    vecs[9]  = '{8'hF5, 1'b0, 0};
    vecs[10] = '{8'h66, 1'b0, 0};
    vecs[11] = '{8'h35, 1'b1, 0};
    vecs[12] = '{8'h99, 1'b1, 0};

    bus.psram_ce   = 1'b1;
    bus.psram_sclk = 1'b0;
    bus.sio_in     = 4'h0;
    reset          = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_sio_out", 64'(bus.sio_out), 64'h0);
    check("rst_sio_oe", 64'(bus.sio_oe), 64'h0);
    check("rst_qpi", 64'(bus.qpi_mode), 64'h0);
    check("rst_bad_cmd", 64'(bus.bad_cmd), 64'h0);

    // Boot: reset-enable, reset, read ID, enter quad.
    ce_low(); spi_byte(CMD_RSTEN); ce_high();
    ce_low(); spi_byte(CMD_RST);   ce_high();
    check("boot_qpi_after_rst", 64'(bus.qpi_mode), 64'h0);
    ce_low();
    spi_byte(CMD_RDID);
    for (int i = 0; i < 3; i++) spi_byte(8'h00);
    id_got = '0;
    oe_ok  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      sclk_cycle(4'h0, q, oe);
      id_got[63-i] = q[1];
      if (!oe) oe_ok = 1'b0;
    end
    extra = '0;
    for (int i = 0; i < 4; i++) begin
      sclk_cycle(4'h0, q, oe);
      extra |= q;
    end
    ce_high();
    check("rdid_value", id_got, ID_VALUE);
    check("rdid_oe", 64'(oe_ok), 64'h1);
    check("rdid_tail_zero", 64'(extra), 64'h0);
    check("rdid_oe_after_ce", 64'(bus.sio_oe), 64'h0);
    ce_low(); spi_byte(CMD_QPI_EN); ce_high();
    check("boot_qpi_on", 64'(bus.qpi_mode), 64'h1);
    check("boot_no_bad", 64'(bad_cnt), 64'h0);

    // Single-command table, sent in whichever mode is currently active.
    cur_qpi = 1'b1;
    for (int i = 0; i < 13; i++) begin
      bad_before = bad_cnt;
      ce_low();
      if (cur_qpi) quad_byte(vecs[i].op);
      else         spi_byte(vecs[i].op);
      tick(2);
      check($sformatf("cmd%0d_%h_oe", i, vecs[i].op), 64'(bus.sio_oe), 64'h0);
      ce_high();
      check($sformatf("cmd%0d_%h_qpi", i, vecs[i].op), 64'(bus.qpi_mode), 64'(vecs[i].exp_qpi));
      check($sformatf("cmd%0d_%h_bad", i, vecs[i].op), 64'(bad_cnt - bad_before), 64'(vecs[i].exp_bad));
      cur_qpi = vecs[i].exp_qpi;
    end

    // Quad write 0x00..0x3F at 0x40 and read it back.
    for (int i = 0; i < 64; i++) wr_buf[i] = 8'(i);
    qwrite(24'h000040, 64);
    check("wr40_oe_low", 64'(wr_oe_any), 64'h0);
    qread(24'h000040, 64);
    check("rd40_oe_high", 64'(rd_oe_all), 64'h1);
    for (int i = 0; i < 64; i++) check($sformatf("rd40_byte%0d", i), 64'(rd_buf[i]), 64'(i));

    // Address wrap at the top of the array.
    wr_buf[0] = 8'hAA; wr_buf[1] = 8'hBB; wr_buf[2] = 8'hCC; wr_buf[3] = 8'hDD;
    qwrite(24'(DEPTH - 2), 4);
    qread(24'(DEPTH - 2), 2);
    check("wrap_top_m2", 64'(rd_buf[0]), 64'hAA);
    check("wrap_top_m1", 64'(rd_buf[1]), 64'hBB);
    qread(24'h000000, 2);
    check("wrap_0", 64'(rd_buf[0]), 64'hCC);
    check("wrap_1", 64'(rd_buf[1]), 64'hDD);

    // CE raised after three data nibbles: one full byte lands, the half byte does not.
    wr_buf[0] = 8'h11; wr_buf[1] = 8'h22;
    qwrite(24'h000100, 2);
    ce_low();
    quad_byte(CMD_QWRITE);
    quad_addr(24'h000100);
    sclk_cycle(4'h5, q, oe);
    sclk_cycle(4'hA, q, oe);
    sclk_cycle(4'h7, q, oe);
    bus.psram_ce = 1'b1;
    tick(1);
    check("ce_abort_wr_oe", 64'(bus.sio_oe), 64'h0);
    tick(2);
    qread(24'h000100, 2);
    check("ce_abort_byte0", 64'(rd_buf[0]), 64'h5A);
    check("ce_abort_byte1", 64'(rd_buf[1]), 64'h22);

    // CE raised mid read burst releases the bus in one cycle.
    ce_low();
    quad_byte(CMD_QREAD);
    quad_addr(24'h000040);
    for (int i = 0; i < 9; i++) sclk_cycle(4'h0, q, oe);
    check("ce_abort_rd_oe_before", 64'(bus.sio_oe), 64'h1);
    bus.psram_ce = 1'b1;
    tick(1);
    check("ce_abort_rd_oe_after", 64'(bus.sio_oe), 64'h0);
    tick(2);

    // Reset during a read burst.
    ce_low();
    quad_byte(CMD_QREAD);
    quad_addr(24'h000040);
    for (int i = 0; i < 8; i++) sclk_cycle(4'h0, q, oe);
    check("rst_abort_oe_before", 64'(bus.sio_oe), 64'h1);
    reset = 1'b1;
    tick(1);
    check("rst_abort_oe", 64'(bus.sio_oe), 64'h0);
    check("rst_abort_qpi", 64'(bus.qpi_mode), 64'h0);
    check("rst_abort_state", 64'(dut.state_q), 64'(ST_IDLE));
    reset        = 1'b0;
    bus.psram_ce = 1'b1;
    tick(2);

    // Array contents survive reset.
    ce_low(); spi_byte(CMD_QPI_EN); ce_high();
    qread(24'h000040, 2);
    check("post_rst_byte0", 64'(rd_buf[0]), 64'h00);
    check("post_rst_byte1", 64'(rd_buf[1]), 64'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
